// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial feeder for the configuration shift chain (optional CRC check: CONFIG_LOADER_CRC_EN)
`timescale 1ns/1ps

module config_loader #(
    parameter int CHAIN_LENGTH = 64,
    parameter int WORD_WIDTH   = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cfg_data,
    output logic                  cfg_enable,
    output logic                  cfg_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int WORDS_NEEDED = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int BL_W         = $clog2(WORD_WIDTH + 1);

    localparam logic [COUNT_WIDTH-1:0] CHAIN_LEN_C = COUNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [COUNT_WIDTH-1:0] WORDS_C     = COUNT_WIDTH'(WORDS_NEEDED);
    localparam logic [COUNT_WIDTH-1:0] ONE_C       = COUNT_WIDTH'(1);
    localparam logic [BL_W-1:0]        WORD_BITS_C = BL_W'(WORD_WIDTH);
    localparam logic [BL_W-1:0]        BL_ONE_C    = BL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  buf_q, buf_d;
    logic [BL_W-1:0]        bits_left_q, bits_left_d;
    logic [COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
    logic                   cfg_data_q, cfg_data_d;
    logic                   cfg_enable_q, cfg_enable_d;
    logic                   cfg_nreset_q, cfg_nreset_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   in_ready_c;
    logic                   accept;

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_fail_q, crc_fail_d;
    logic       error_q, error_d;
    logic [7:0] check_byte;

    // CRC-8, polynomial 0x07, one serial bit per call, MSB-first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // The check value lives in the low byte of the word, zero-padded for narrow words
    if (WORD_WIDTH >= 8) begin : g_check_wide
        assign check_byte = in_data[7:0];
    end else begin : g_check_narrow
        assign check_byte = {{(8 - WORD_WIDTH){1'b0}}, in_data};
    end
`endif

    // Ready is combinational so a word can be taken in the same cycle the last buffered bit goes out
    always_comb begin
        in_ready_c = 1'b0;
        if (state_q == S_SHIFT) begin
            in_ready_c = (bits_left_q <= BL_ONE_C) && (word_count_q < WORDS_C);
        end
`ifdef CONFIG_LOADER_CRC_EN
        else if (state_q == S_CHECK) begin
            in_ready_c = 1'b1;
        end
`endif
    end

    assign accept = in_valid && in_ready_c;

    // Next-state and registered-output decode; outputs reflect the state of the previous cycle
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        bits_left_d  = bits_left_q;
        bit_count_d  = bit_count_q;
        word_count_d = word_count_q;
        cfg_data_d   = cfg_data_q;
        cfg_enable_d = 1'b0;
        cfg_nreset_d = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        crc_d        = crc_q;
        crc_fail_d   = crc_fail_q;
        error_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cfg_data_d = 1'b0;
                if (start) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                cfg_nreset_d = 1'b0;
                busy_d       = 1'b1;
                buf_d        = '0;
                bits_left_d  = '0;
                bit_count_d  = '0;
                word_count_d = '0;
`ifdef CONFIG_LOADER_CRC_EN
                crc_d        = 8'h00;
                crc_fail_d   = 1'b0;
`endif
                state_d      = S_SHIFT;
            end

            S_SHIFT: begin
                busy_d = 1'b1;
                // Emit the buffer MSB; an empty buffer leaves cfg_data holding its last bit
                if ((bits_left_q != '0) && (bit_count_q < CHAIN_LEN_C)) begin
                    cfg_enable_d = 1'b1;
                    cfg_data_d   = buf_q[WORD_WIDTH-1];
                    buf_d        = buf_q << 1;
                    bits_left_d  = bits_left_q - BL_ONE_C;
                    bit_count_d  = bit_count_q + ONE_C;
`ifdef CONFIG_LOADER_CRC_EN
                    crc_d        = crc8_step(crc_q, buf_q[WORD_WIDTH-1]);
`endif
                end
                // A new word overwrites the buffer as its last bit is being emitted
                if (accept) begin
                    buf_d        = in_data;
                    bits_left_d  = WORD_BITS_C;
                    word_count_d = word_count_q + ONE_C;
                end
                // Chain full: drop the unused tail of the final word
                if (bit_count_d == CHAIN_LEN_C) begin
                    bits_left_d = '0;
`ifdef CONFIG_LOADER_CRC_EN
                    state_d     = S_CHECK;
`else
                    state_d     = S_DONE;
`endif
                end
            end

`ifdef CONFIG_LOADER_CRC_EN
            S_CHECK: begin
                busy_d = 1'b1;
                if (accept) begin
                    crc_fail_d = (check_byte != crc_q);
                    state_d    = S_DONE;
                end
            end
`endif

            S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end else begin
                    done_d  = 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                    error_d = crc_fail_q;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            bits_left_q  <= '0;
            bit_count_q  <= '0;
            word_count_q <= '0;
            cfg_data_q   <= 1'b0;
            cfg_enable_q <= 1'b0;
            cfg_nreset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            bits_left_q  <= bits_left_d;
            bit_count_q  <= bit_count_d;
            word_count_q <= word_count_d;
            cfg_data_q   <= cfg_data_d;
            cfg_enable_q <= cfg_enable_d;
            cfg_nreset_q <= cfg_nreset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    // Running CRC of the shifted stream and the result of the check word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q      <= 8'h00;
            crc_fail_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            crc_q      <= crc_d;
            crc_fail_q <= crc_fail_d;
            error_q    <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready   = in_ready_c;
    assign cfg_data   = cfg_data_q;
    assign cfg_enable = cfg_enable_q;
    assign cfg_nreset = cfg_nreset_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - randomized self-checking bench for config_loader
`timescale 1ns/1ps

module tb_config_loader;

`ifdef CONFIG_LOADER_CRC_EN
    localparam int CL = 8;
    localparam int NW = 2;
`else
    localparam int CL = 12;
    localparam int NW = 2;
`endif
    localparam int WW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, cfg_data, cfg_enable, cfg_nreset, busy, done, error;

    config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .cfg_data(cfg_data),
        .cfg_enable(cfg_enable), .cfg_nreset(cfg_nreset), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
        logic [8:0] t;
        t = {c, 1'b0};
        if (c[7] ^ b) t[7:0] = t[7:0] ^ 8'h07;
        return t[7:0];
    endfunction

    function automatic logic [7:0] crc_word(input logic [WW-1:0] w);
        logic [7:0] c = 8'h00;
        for (int k = WW - 1; k >= 0; k--) c = crc_bit(c, w[k]);
        return c;
    endfunction

    // Reference model state: expected serial stream of the current load
    bit         exp_q[$];
    bit         obs[$];
    int         pushed = 0, en_load = 0, hs_load = 0, ir_load = 0;
    int         first_en = -1, last_en = -1, cyc = 0, tot_nrst_low = 0;
    logic [7:0] mcrc = 8'h00;
    bit         prev_nrst = 0, prev_done = 0, prev_en = 0;
`ifdef CONFIG_LOADER_CRC_EN
    bit         exp_err = 0;
`endif

    function automatic void model_clear();
        exp_q.delete();
        obs.delete();
        pushed = 0; en_load = 0; hs_load = 0; ir_load = 0;
        first_en = -1; last_en = -1; mcrc = 8'h00;
    endfunction

    // Compare process: sample away from the rising edge and check against the model
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            model_clear();
            prev_nrst = 0; prev_done = 0; prev_en = 0;
        end else begin
            if (!cfg_nreset) begin
                tot_nrst_low++;
                if (prev_nrst) model_clear();
            end
            if (in_ready) ir_load++;
            if (in_valid && in_ready) begin
                hs_load++;
                if (pushed < CL) begin
                    for (int i = WW - 1; i >= 0; i--) begin
                        if (pushed < CL) begin
                            exp_q.push_back(in_data[i]);
                            mcrc = crc_bit(mcrc, in_data[i]);
                            pushed++;
                        end
                    end
                end
`ifdef CONFIG_LOADER_CRC_EN
                else begin
                    exp_err = (in_data[7:0] != mcrc);
                end
`endif
            end
            if (cfg_enable) begin
                en_load++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                obs.push_back(cfg_data);
                if (exp_q.size() == 0) chk("enable_beyond_data", en_load, pushed);
                else chk("cfg_data", int'(cfg_data), int'(exp_q.pop_front()));
            end
            chk("done_and_busy", int'(done && busy), 0);
`ifndef CONFIG_LOADER_CRC_EN
            chk("error_tied_low", int'(error), 0);
`endif
            if (done && !prev_done) begin
                chk("enables_per_load", en_load, CL);
                chk("leftover_bits", exp_q.size(), 0);
`ifdef CONFIG_LOADER_CRC_EN
                chk("handshakes", hs_load, (CL + WW - 1) / WW + 1);
                chk("error_flag", int'(error), int'(exp_err));
`else
                chk("handshakes", hs_load, (CL + WW - 1) / WW);
                chk("done_after_last_enable", int'(prev_en), 1);
`endif
            end
            prev_nrst = cfg_nreset;
            prev_done = done;
            prev_en   = cfg_enable;
        end
    end

    logic [WW-1:0] words[4];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // gap >= 0: hold in_valid low for that many ready cycles before word 1; gap < 0: random valid
    task automatic drive(input int n, input int gap, input int start_at, input int reset_at,
                         output bit aborted);
        int i = 0, g = 0, budget = 0;
        bit hs, started = 0;
        aborted = 0;
        while (i < n && budget < 400) begin
            budget++;
            if (reset_at >= 0 && en_load >= reset_at) begin
                reset = 1'b1; in_valid = 1'b0; start = 1'b0;
                #1;
                chk("reset_cfg_nreset", int'(cfg_nreset), 0);
                chk("reset_cfg_enable", int'(cfg_enable), 0);
                chk("reset_busy", int'(busy), 0);
                chk("reset_in_ready", int'(in_ready), 0);
                repeat (2) @(posedge clock);
                @(negedge clock); reset = 1'b0;
                @(posedge clock); #1;
                chk("post_reset_nreset", int'(cfg_nreset), 1);
                aborted = 1;
                return;
            end
            if (start_at >= 0 && !started && en_load >= start_at) begin
                start = 1'b1; started = 1;
            end
            in_data = words[i];
            if (gap < 0) in_valid = ($urandom_range(0, 3) != 0);
            else in_valid = !(i == 1 && g < gap);
            @(negedge clock);
            hs = in_valid && in_ready;
            if (i == 1 && !in_valid && in_ready) g++;
            @(posedge clock); #1;
            start = 1'b0;
            if (hs) i++;
        end
        in_valid = 1'b0;
        chk("words_accepted", i, n);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin
            @(posedge clock); #1;
            c++;
        end
        chk("done_reached", int'(done), 1);
    endtask

    task automatic load(input int gap, input int start_at, input int reset_at);
        int snap;
        bit ab;
        snap = tot_nrst_low;
        pulse_start();
        drive(NW, gap, start_at, reset_at, ab);
        if (!ab) begin
            wait_done(200);
            chk("nreset_pulses", tot_nrst_low - snap, 1);
        end
    endtask

    function automatic int packed_obs();
        int v = 0;
        foreach (obs[k]) v = (v << 1) | int'(obs[k]);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int snap;
        bit ab;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cfg_data", int'(cfg_data), 0);
        chk("rst_cfg_enable", int'(cfg_enable), 0);
        chk("rst_cfg_nreset", int'(cfg_nreset), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_nreset_high", int'(cfg_nreset), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

`ifndef CONFIG_LOADER_CRC_EN
        words[0] = 8'hA5; words[1] = 8'h3C;
        load(0, -1, -1);
        chk("t1_bit_count", obs.size(), 12);
        chk("t1_stream", packed_obs(), 12'b1010_0101_0011);
        chk("t1_ready_cycles", ir_load, 2);
        chk("t1_enable_span", last_en - first_en + 1, 12);

        load(5, -1, -1);
        chk("t2_stream", packed_obs(), 12'b1010_0101_0011);
        chk("t2_enable_span", last_en - first_en + 1, 17);

        load(0, 4, -1);
        chk("t3_stream", packed_obs(), 12'b1010_0101_0011);

        load(0, -1, 6);
        words[0] = 8'hFF; words[1] = 8'hFF;
        load(0, -1, -1);
        chk("t4_stream", packed_obs(), 12'hFFF);
`else
        words[0] = 8'h01; words[1] = 8'h07;
        load(0, -1, -1);
        chk("crc_good_error", int'(error), 0);
        chk("crc_good_stream", packed_obs(), 8'h01);
        words[1] = 8'h06;
        load(0, -1, -1);
        chk("crc_bad_error", int'(error), 1);
        chk("crc_bad_enables", en_load, 8);
`endif

        // Restart from DONE: done drops on the next edge, then a clear pulse and a full reload
        chk("pre_restart_done", int'(done), 1);
        snap = tot_nrst_low;
        words[0] = 8'h5A;
`ifdef CONFIG_LOADER_CRC_EN
        words[1] = crc_word(8'h5A);
`else
        words[1] = 8'hC3;
`endif
        pulse_start();
        chk("restart_done_clear", int'(done), 0);
        @(posedge clock); #1;
        chk("restart_nreset_low", int'(cfg_nreset), 0);
        chk("restart_busy", int'(busy), 1);
        drive(NW, 0, -1, -1, ab);
        wait_done(200);
        chk("restart_nreset_pulses", tot_nrst_low - snap, 1);
`ifdef CONFIG_LOADER_CRC_EN
        chk("restart_error", int'(error), 0);
`endif

        for (int r = 0; r < 20; r++) begin
            words[0] = WW'($urandom);
`ifdef CONFIG_LOADER_CRC_EN
            words[1] = ($urandom_range(0, 1) == 1) ? crc_word(words[0])
                                                   : crc_word(words[0]) ^ 8'($urandom_range(1, 255));
`else
            words[1] = WW'($urandom);
`endif
            load(-1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
